// File: rtl/nios_req_seq_pkg.sv
// Shared constants and FSM state type for the Nios request sequencer.
// The optional interrupt logic is enabled with NIOS_REQ_SEQ_IRQ_EN.
package nios_req_seq_pkg;

    localparam logic [1:0] ADDR_REQ     = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_RESULT  = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_DONE      = 1;
    localparam int unsigned ST_TMO       = 2;
    localparam int unsigned ST_OVF       = 3;
    localparam int unsigned ST_COUNT_LSB = 8;
    localparam int unsigned ST_IE_LSB    = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/nios_req_fifo.sv
// Synchronous FIFO with first-word head output; a pop frees room for a
// push in the same cycle even when full.
module nios_req_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/nios_request_sequencer.sv
// Avalon-MM request sequencer: queues software requests, issues them over
// valid/ready and records response or timeout. Optional irq: NIOS_REQ_SEQ_IRQ_EN.
module nios_request_sequencer
    import nios_req_seq_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned TIMEOUT_DEFAULT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              req_valid,
    output logic [DATA_W-1:0] req_data,
    input  logic              req_ready,
`ifdef NIOS_REQ_SEQ_IRQ_EN
    output logic              irq,
`endif
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_e        state_q, state_d;
    logic              req_valid_q, req_valid_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [15:0]       timer_q, timer_d;
    logic [15:0]       timeout_q, timeout_d;
    logic              done_q, done_d, tmo_q, tmo_d, ovf_q, ovf_d;
    logic              set_done, set_tmo, set_ovf;

    logic              wr_en, wr_req, wr_status, wr_timeout;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic [CW-1:0]     fifo_count;

    assign wr_en      = chipselect && !write_n;
    assign wr_req     = wr_en && (address == ADDR_REQ);
    assign wr_status  = wr_en && (address == ADDR_STATUS);
    assign wr_timeout = wr_en && (address == ADDR_TIMEOUT);
    assign set_ovf    = wr_req && fifo_full && !fifo_pop;

    nios_req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_req),
        .pop     (fifo_pop),
        .wdata   (writedata),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_data_d  = req_data_q;
        result_d    = result_q;
        timer_d     = timer_q;
        fifo_pop    = 1'b0;
        set_done    = 1'b0;
        set_tmo     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    req_data_d  = fifo_rdata;
                    req_valid_d = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    timer_d     = timeout_q;
                    state_d     = StWait;
                end
            end
            StWait: begin
                // Timer loaded with 0 never expires; response beats expiry.
                if (resp_valid) begin
                    result_d = resp_data;
                    set_done = 1'b1;
                    state_d  = StIdle;
                end else if (timer_q == 16'd1) begin
                    timer_d = '0;
                    set_tmo = 1'b1;
                    state_d = StIdle;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Hardware set takes priority over a same-cycle W1C.
    assign done_d    = (done_q & ~(wr_status & writedata[ST_DONE])) | set_done;
    assign tmo_d     = (tmo_q  & ~(wr_status & writedata[ST_TMO]))  | set_tmo;
    assign ovf_d     = (ovf_q  & ~(wr_status & writedata[ST_OVF]))  | set_ovf;
    assign timeout_d = wr_timeout ? writedata[15:0] : timeout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            req_valid_q <= 1'b0;
            req_data_q  <= '0;
            result_q    <= '0;
            timer_q     <= '0;
            timeout_q   <= 16'(TIMEOUT_DEFAULT);
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_data_q  <= req_data_d;
            result_q    <= result_d;
            timer_q     <= timer_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            ovf_q       <= ovf_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_data  = req_data_q;

`ifdef NIOS_REQ_SEQ_IRQ_EN
    logic [2:0] ie_q;
    logic       irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (wr_status) ie_q <= writedata[ST_IE_LSB +: 3];
            irq_q <= |({ovf_q, tmo_q, done_q} & ie_q);
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_STATUS: begin
                readdata[ST_BUSY]           = (state_q != StIdle);
                readdata[ST_DONE]           = done_q;
                readdata[ST_TMO]            = tmo_q;
                readdata[ST_OVF]            = ovf_q;
                readdata[ST_COUNT_LSB +: 8] = 8'(fifo_count);
`ifdef NIOS_REQ_SEQ_IRQ_EN
                readdata[ST_IE_LSB +: 3]    = ie_q;
`endif
            end
            ADDR_RESULT:  readdata = result_q;
            ADDR_TIMEOUT: readdata[15:0] = timeout_q;
            default:      readdata = '0;
        endcase
    end

endmodule

// File: doc/nios_request_sequencer.md
Name: nios_request_sequencer

Overview:
- Avalon-MM slave peripheral for the Nios system that replaces the bare data_request output PIO.
- Software writes request words. The block queues them in a small FIFO and issues each one, in order, to the fabric-side data source over a valid/ready handshake.
- For each request it waits for a response or a timeout, then exposes the result and status to software through a 4-word register map.

Parameters:
- DATA_W, 32, width of request/response words and of the Avalon data bus.
- FIFO_DEPTH, 4, request queue depth; must be a power of 2, minimum 2.
- TIMEOUT_DEFAULT, 1024, reset value of the TIMEOUT register, in clk cycles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  active-low write strobe.
- writedata  in  DATA_W  Avalon write data.
- readdata  out  DATA_W  Avalon read data, combinational, zero wait states.
- req_valid  out  1  request presented to the fabric.
- req_data  out  DATA_W  request word.
- req_ready  in  1  fabric accepts the request.
- resp_valid  in  1  single-cycle response strobe.
- resp_data  in  DATA_W  response word, qualified by resp_valid.

Behaviour:
- Clock and reset: already decided — reset reset_n, asynchronous, active-low; clock clk.
- Reset values: req_valid=0, req_data=0, FIFO empty, RESULT=0, all sticky flags 0, TIMEOUT=TIMEOUT_DEFAULT, FSM=IDLE.
- Write condition: chipselect && !write_n. Reads are combinational: readdata = mux(address). Unused bits read 0.
- addr 0, REQ:
  - Write pushes writedata into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the word is dropped and OVF is set.
  - Read returns 0.
- addr 1, STATUS:
  - Read layout: bit0 BUSY (FSM != IDLE), bit1 DONE, bit2 TMO, bit3 OVF, bits[15:8] FIFO count.
  - Write: W1C on bits 1-3.
  - Clear-write in the same cycle as a hardware set: set wins.
- addr 2, RESULT: read-only; last captured resp_data.
- addr 3, TIMEOUT: read/write, 16 bits used; 0 disables the timeout.
- FSM:
  - IDLE: when the FIFO is non-empty, pop the head into req_data, assert req_valid, go to ISSUE. Push and pop in the same cycle are both honoured.
  - ISSUE: hold req_valid and req_data stable until req_ready=1. On that cycle, drop req_valid, load the timer with TIMEOUT, go to WAIT.
  - WAIT, on resp_valid: RESULT<=resp_data, set DONE, go to IDLE.
  - WAIT, otherwise: if TIMEOUT!=0, decrement the timer; when the timer reaches 0, set TMO and go to IDLE. The timeout is TIMEOUT cycles after handshake.
- Timing and boundary cases:
  - resp_valid in the same cycle as timer expiry: the response wins; TMO is not set.
  - resp_valid outside WAIT is ignored.
  - Minimum request-to-request spacing is 3 cycles: IDLE, ISSUE, WAIT.
  - FIFO pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
  - A TIMEOUT write during WAIT does not affect the running timer.
  - Reset mid-operation: immediate return to reset values; the queued requests are lost.

Optional Feature:
- Macro: NIOS_REQ_SEQ_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit), registered.
  - irq = (DONE&IE0)|(TMO&IE1)|(OVF&IE2).
  - IE bits are CTRL bits [18:16] of STATUS, read/write, reset 0.
  - irq deasserts the cycle after the causing flag is cleared.
- Undefined: no irq port; STATUS bits [18:16] read 0 and ignore writes.

Decomposition:
- Package nios_req_seq_pkg:
  - register address constants ADDR_REQ=0, ADDR_STATUS=1, ADDR_RESULT=2, ADDR_TIMEOUT=3;
  - STATUS bit-index constants;
  - FSM state enum {IDLE, ISSUE, WAIT}.
- One sub-module: nios_req_fifo, a synchronous FIFO.
  - Interface: push/pop/full/empty/count, with head data visible while non-empty.

Test Plan:
1. Reset, then read all registers -> STATUS=0, RESULT=0, TIMEOUT=1024, req_valid=0.
2. Write REQ=0x0000_00A5; hold req_ready low 5 cycles then high; pulse resp_valid with 0x1234_5678 three cycles later -> req_data=0xA5 stable throughout ISSUE, RESULT=0x12345678, STATUS.DONE=1, BUSY=0.
3. Back-to-back writes 0x1..0x5 while req_ready=0 (FIFO_DEPTH=4):
   - one word is popped into ISSUE, so 0x1..0x5 are all accepted and OVF=0;
   - a sixth write sets OVF=1;
   - requests are later issued in order 1..5.
4. TIMEOUT=10, one request accepted, no response -> TMO=1 exactly 10 cycles after handshake, FSM returns to IDLE; W1C write 0x4 -> TMO=0.
5. TIMEOUT=10, resp_valid on the expiry cycle -> DONE=1, TMO=0, RESULT captured.
6. Assert reset_n low during WAIT with 2 queued requests -> outputs return to reset values immediately; after release, no request is issued.
